csa_521_ctrl: RTL and testbench

CSA_521_CTRL -- requirements
Module: csa_521_ctrl

---
 rtl/csa_521_ctrl_if.sv | 21 ++
 rtl/csa_521_ctrl.sv | 95 +++++++++
 tb/tb_csa_521_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/csa_521_ctrl_if.sv
// csa_521_ctrl_if: requester, datapath and result-FIFO signals of the CSA issue controller
interface csa_521_ctrl_if;
  logic req0_valid, req1_valid, req0_ready, req1_ready;
  logic [25:0] req0_a0, req0_a1, req0_a2, req0_b0, req0_b1;
  logic [25:0] req1_a0, req1_a1, req1_a2, req1_b0, req1_b1;
  logic [25:0] dp_a0, dp_a1, dp_a2, dp_b0, dp_b1, dp_result;
  logic res_valid, res_ready, res_id;
  logic [25:0] res_data;
  modport slave (
    input req0_valid, req1_valid, req0_a0, req0_a1, req0_a2, req0_b0, req0_b1,
    input req1_a0, req1_a1, req1_a2, req1_b0, req1_b1, dp_result, res_ready,
    output req0_ready, req1_ready, dp_a0, dp_a1, dp_a2, dp_b0, dp_b1,
    output res_valid, res_id, res_data
  );
  modport master (
    output req0_valid, req1_valid, req0_a0, req0_a1, req0_a2, req0_b0, req0_b1,
    output req1_a0, req1_a1, req1_a2, req1_b0, req1_b1, dp_result, res_ready,
    input req0_ready, req1_ready, dp_a0, dp_a1, dp_a2, dp_b0, dp_b1,
    input res_valid, res_id, res_data
  );
endinterface

// File: rtl/csa_521_ctrl.sv
// csa_521_ctrl: two-requester issue controller for a 5-input CSA datapath with credit-limited result FIFO (CSA_CTRL_RR_EN selects round-robin arbitration)
module csa_521_ctrl #(
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  csa_521_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [5:0] LIM = 6'(DEPTH);
  logic [2:0] vld, id;
  logic [25:0] b0_hold, b1_hold;
  logic [26:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic [5:0] occ;
  logic gnt, credit, issue, push, pop;
`ifdef CSA_CTRL_RR_EN
  logic last_grant;
`endif

  // arbitration, credit from queued plus in-flight results, and FIFO head presentation
  always_comb begin
    occ = 6'(cnt) + 6'(vld[0]) + 6'(vld[1]) + 6'(vld[2]);
    credit = !rst && occ < LIM;
`ifdef CSA_CTRL_RR_EN
    gnt = (bus.req0_valid && bus.req1_valid) ? !last_grant : !bus.req0_valid;
`else
    gnt = !bus.req0_valid;
`endif
    bus.req0_ready = credit && bus.req0_valid && !gnt;
    bus.req1_ready = credit && bus.req1_valid && gnt;
    issue = bus.req0_ready || bus.req1_ready;
    push = vld[2];
    bus.res_valid = cnt != '0;
    bus.res_id = bus.res_valid && mem[rp][26];
    bus.res_data = bus.res_valid ? mem[rp][25:0] : '0;
    pop = bus.res_valid && bus.res_ready;
  end

  // operand launch: A enters stage 0 at issue, B is held one cycle to meet the second datapath stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      id <= '0;
      b0_hold <= '0;
      b1_hold <= '0;
      bus.dp_a0 <= '0;
      bus.dp_a1 <= '0;
      bus.dp_a2 <= '0;
      bus.dp_b0 <= '0;
      bus.dp_b1 <= '0;
    end else begin
      vld <= {vld[1:0], issue};
      id <= {id[1:0], gnt};
      if (issue) begin
        bus.dp_a0 <= gnt ? bus.req1_a0 : bus.req0_a0;
        bus.dp_a1 <= gnt ? bus.req1_a1 : bus.req0_a1;
        bus.dp_a2 <= gnt ? bus.req1_a2 : bus.req0_a2;
        b0_hold <= gnt ? bus.req1_b0 : bus.req0_b0;
        b1_hold <= gnt ? bus.req1_b1 : bus.req0_b1;
      end
      if (vld[0]) begin
        bus.dp_b0 <= b0_hold;
        bus.dp_b1 <= b1_hold;
      end
    end
  end

`ifdef CSA_CTRL_RR_EN
  // remember who won the last issue so the other requester goes next on contention
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant <= 1'b1;
    else if (issue) last_grant <= gnt;
  end
`endif

  // result FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      if (push != pop) cnt <= push ? cnt + (AW+1)'(1) : cnt - (AW+1)'(1);
    end
  end

  // result FIFO storage: requester id alongside the unmodified datapath sum
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= {id[2], bus.dp_result};
  end
endmodule

// File: tb/tb_csa_521_ctrl.sv
// tb_csa_521_ctrl: directed and randomized checks of csa_521_ctrl against a queue-based reference model
module tb_csa_521_ctrl;
  localparam int DEPTH = 4;
  logic clk = 0;
  logic rst = 1;
  csa_521_ctrl_if bus();
  csa_521_ctrl #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  typedef struct { int rdy; logic id; logic [25:0] sum; } ent_t;
  ent_t q[$];
  logic [25:0] op [2][5];
  logic [25:0] exp_a [3];
  logic [25:0] s1;
  int checks = 0, failures = 0, cyc = 0, n0, n1;
`ifdef CSA_CTRL_RR_EN
  logic lg = 1'b1;
`endif

  // reference datapath: A summed in the first register, B added in the second
  always @(posedge clk) begin
    s1 <= bus.dp_a0 + bus.dp_a1 + bus.dp_a2;
    bus.dp_result <= s1 + bus.dp_b0 + bus.dp_b1;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, got, want);
    end
  endtask

  task automatic set_req(input int n, input logic v, input logic [25:0] a0, a1, a2, b0, b1);
    op[n] = '{a0, a1, a2, b0, b1};
    if (n == 0) begin
      bus.req0_valid = v; bus.req0_a0 = a0; bus.req0_a1 = a1; bus.req0_a2 = a2; bus.req0_b0 = b0; bus.req0_b1 = b1;
    end else begin
      bus.req1_valid = v; bus.req1_a0 = a0; bus.req1_a1 = a1; bus.req1_a2 = a2; bus.req1_b0 = b0; bus.req1_b1 = b1;
    end
  endtask

  task automatic rnd_req(input int n, input logic v);
    set_req(n, v, 26'($urandom()), 26'($urandom()), 26'($urandom()), 26'($urandom()), 26'($urandom()));
  endtask

  // model: every accepted operand set is one entry, counted against credit until popped, visible 4 cycles after its issue cycle
  task automatic model_step();
    logic g, e0, e1, vis;
    logic [25:0] sum;
    int k;
    if (rst) begin
      q.delete();
      exp_a = '{default: '0};
`ifdef CSA_CTRL_RR_EN
      lg = 1'b1;
`endif
      chk("rst_ready", 32'({bus.req1_ready, bus.req0_ready}), 0);
      chk("rst_res", 32'({bus.res_valid, bus.res_id}), 0);
      chk("rst_data", 32'(bus.res_data), 0);
      chk("rst_dp", 32'(bus.dp_a0 | bus.dp_a1 | bus.dp_a2 | bus.dp_b0 | bus.dp_b1), 0);
    end else begin
`ifdef CSA_CTRL_RR_EN
      g = (bus.req0_valid && bus.req1_valid) ? !lg : !bus.req0_valid;
`else
      g = !bus.req0_valid;
`endif
      e0 = bus.req0_valid && !g && q.size() < DEPTH;
      e1 = bus.req1_valid && g && q.size() < DEPTH;
      chk("ready0", 32'(bus.req0_ready), 32'(e0));
      chk("ready1", 32'(bus.req1_ready), 32'(e1));
      vis = q.size() > 0 && q[0].rdy <= cyc;
      chk("res_valid", 32'(bus.res_valid), 32'(vis));
      if (vis) begin
        chk("res_id", 32'(bus.res_id), 32'(q[0].id));
        chk("res_data", 32'(bus.res_data), 32'(q[0].sum));
      end
      chk("dp_a0", 32'(bus.dp_a0), 32'(exp_a[0]));
      chk("dp_a1", 32'(bus.dp_a1), 32'(exp_a[1]));
      chk("dp_a2", 32'(bus.dp_a2), 32'(exp_a[2]));
      if (vis && bus.res_ready) void'(q.pop_front());
      if (e0 || e1) begin
        k = e1 ? 1 : 0;
        sum = op[k][0] + op[k][1] + op[k][2] + op[k][3] + op[k][4];
        q.push_back('{cyc + 4, e1, sum});
        exp_a = '{op[k][0], op[k][1], op[k][2]};
`ifdef CSA_CTRL_RR_EN
        lg = e1;
`endif
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    bus.req0_valid = 0;
    bus.req1_valid = 0;
    repeat (n) cycle();
  endtask

  initial begin
    bus.res_ready = 0;
    set_req(0, 0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0, 0);
    repeat (3) cycle();
    rst = 0;
    bus.res_ready = 1;
    set_req(0, 1, 1, 2, 3, 4, 5);
    #1 chk("single_ready", 32'(bus.req0_ready), 1);
    cycle();
    bus.req0_valid = 0;
    repeat (2) cycle();
    chk("single_early", 32'(bus.res_valid), 0);
    cycle();
    chk("single_valid", 32'(bus.res_valid), 1);
    chk("single_data", 32'(bus.res_data), 15);
    chk("single_id", 32'(bus.res_id), 0);
    idle(2);
    set_req(1, 1, 26'h3FFFFFF, 1, 0, 0, 0);
    #1 cycle();
    bus.req1_valid = 0;
    repeat (3) cycle();
    chk("wrap_valid", 32'(bus.res_valid), 1);
    chk("wrap_data", 32'(bus.res_data), 0);
    chk("wrap_id", 32'(bus.res_id), 1);
    idle(6);
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 10; i++) begin
      rnd_req(0, 1);
      rnd_req(1, 1);
      #1;
      n0 += int'(bus.req0_ready);
      n1 += int'(bus.req1_ready);
      cycle();
    end
`ifdef CSA_CTRL_RR_EN
    chk("arb_n0", 32'(n0), 4);
    chk("arb_n1", 32'(n1), 4);
`else
    chk("arb_n0", 32'(n0), 8);
    chk("arb_n1", 32'(n1), 0);
`endif
    idle(6);
    bus.res_ready = 0;
    n0 = 0;
    for (int i = 0; i < 10; i++) begin
      rnd_req(0, 1);
      #1;
      n0 += int'(bus.req0_ready);
      cycle();
    end
    chk("full_issues", 32'(n0), 4);
    #1 chk("full_ready", 32'(bus.req0_ready), 0);
    bus.res_ready = 1;
    for (int i = 0; i < 12; i++) begin
      rnd_req(0, 1);
      cycle();
    end
    idle(8);
    rnd_req(0, 1);
    cycle();
    rnd_req(0, 1);
    cycle();
    bus.req0_valid = 0;
    rst = 1;
    #1;
    chk("mid_rst_valid", 32'(bus.res_valid), 0);
    chk("mid_rst_dp", 32'(bus.dp_a0), 0);
    cycle();
    rst = 0;
    idle(6);
    chk("post_rst_empty", 32'(bus.res_valid), 0);
    set_req(0, 1, 7, 8, 9, 10, 11);
    cycle();
    bus.req0_valid = 0;
    repeat (3) cycle();
    chk("post_rst_valid", 32'(bus.res_valid), 1);
    chk("post_rst_data", 32'(bus.res_data), 45);
    idle(4);
    for (int i = 0; i < 600; i++) begin
      rnd_req(0, $urandom_range(0, 3) != 0);
      rnd_req(1, $urandom_range(0, 3) != 0);
      bus.res_ready = $urandom_range(0, 9) < 7;
      rst = $urandom_range(0, 199) == 0;
      cycle();
    end
    rst = 0;
    bus.res_ready = 1;
    idle(10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
